// File: rtl/apb_alarm_host.sv
// APB initiator for the alarm peripheral: turns single valid/ready commands into
// SETUP/ACCESS transfers with a wait-state timeout and a one-cycle response pulse.
`timescale 1ns/1ps
module apb_alarm_host #(
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [31:0] ADDR_MAX = 32'h8
) (
  input  logic        pclk_i,
  input  logic        preset_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_write_i,
  input  logic [31:0] cmd_addr_i,
  input  logic [31:0] cmd_wdata_i,
  input  logic [3:0]  cmd_strb_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic [31:0] paddr_o,
  output logic        psel_o,
  output logic        penable_o,
  output logic        pwrite_o,
  output logic [31:0] pwdata_o,
  output logic [3:0]  pstrb_o,
  input  logic        pready_i,
  input  logic [31:0] prdata_i,
  input  logic        pslverr_i
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  localparam logic [8:0] TIMEOUT_C = 9'(TIMEOUT);

  state_t      state_r, state_nx_s;
  logic [7:0]  wait_cnt_r;
  logic [8:0]  wait_next_s;
  logic        timeout_hit_s;
  logic        addr_bad_s;
  logic        accept_s;
  logic [31:0] rdata_nx_s;
  logic        err_nx_s;

  logic        cmd_ready_r, rsp_valid_r, rsp_err_r, psel_r, penable_r, pwrite_r;
  logic [31:0] rsp_rdata_r, paddr_r, pwdata_r;
  logic [3:0]  pstrb_r;

  assign addr_bad_s    = (cmd_addr_i[1:0] != 2'b00) || (cmd_addr_i > ADDR_MAX);
  assign wait_next_s   = {1'b0, wait_cnt_r} + 9'd1;
  assign timeout_hit_s = (wait_next_s >= TIMEOUT_C);

  // Next-state and response-capture logic; pready wins over a same-cycle timeout.
  always_comb begin
    state_nx_s = state_r;
    rdata_nx_s = rsp_rdata_r;
    err_nx_s   = rsp_err_r;
    accept_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          accept_s = 1'b1;
          if (addr_bad_s) begin
            state_nx_s = ST_RESP;
            rdata_nx_s = 32'h0000_0000;
            err_nx_s   = 1'b1;
          end else begin
            state_nx_s = ST_SETUP;
          end
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_SETUP: state_nx_s = ST_ACCESS;
      ST_ACCESS: begin
        if (pready_i) begin
          state_nx_s = ST_RESP;
          rdata_nx_s = pwrite_r ? 32'h0000_0000 : prdata_i;
          err_nx_s   = pslverr_i;
        end else if (timeout_hit_s) begin
          state_nx_s = ST_RESP;
          rdata_nx_s = 32'h0000_0000;
          err_nx_s   = 1'b1;
        end else begin
          state_nx_s = ST_ACCESS;
        end
      end
      ST_RESP: state_nx_s = ST_IDLE;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // State register with handshake, bus-phase and response outputs registered from next state.
  always_ff @(posedge pclk_i or posedge preset_i) begin
    if (preset_i) begin
      state_r     <= ST_IDLE;
      cmd_ready_r <= 1'b1;
      psel_r      <= 1'b0;
      penable_r   <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 32'h0000_0000;
      rsp_err_r   <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      cmd_ready_r <= (state_nx_s == ST_IDLE);
      psel_r      <= (state_nx_s == ST_SETUP) || (state_nx_s == ST_ACCESS);
      penable_r   <= (state_nx_s == ST_ACCESS);
      rsp_valid_r <= (state_nx_s == ST_RESP);
      rsp_rdata_r <= rdata_nx_s;
      rsp_err_r   <= err_nx_s;
    end
  end

  // Holding registers feed the APB address/data lines directly and stay stable until the next accept.
  always_ff @(posedge pclk_i or posedge preset_i) begin
    if (preset_i) begin
      pwrite_r <= 1'b0;
      paddr_r  <= 32'h0000_0000;
      pwdata_r <= 32'h0000_0000;
      pstrb_r  <= 4'h0;
    end else if (accept_s) begin
      pwrite_r <= cmd_write_i;
      paddr_r  <= cmd_addr_i;
      pwdata_r <= cmd_wdata_i;
      pstrb_r  <= cmd_write_i ? cmd_strb_i : 4'h0;
    end
  end

  // Wait counter: cleared entering SETUP, counts ACCESS cycles, saturates at all-ones.
  always_ff @(posedge pclk_i or posedge preset_i) begin
    if (preset_i) begin
      wait_cnt_r <= 8'd0;
    end else if (state_nx_s == ST_SETUP) begin
      wait_cnt_r <= 8'd0;
    end else if ((state_r == ST_ACCESS) && (wait_cnt_r != 8'hFF)) begin
      wait_cnt_r <= wait_cnt_r + 8'd1;
    end
  end

  assign cmd_ready_o = cmd_ready_r;
  assign rsp_valid_o = rsp_valid_r;
  assign rsp_rdata_o = rsp_rdata_r;
  assign rsp_err_o   = rsp_err_r;
  assign psel_o      = psel_r;
  assign penable_o   = penable_r;
  assign pwrite_o    = pwrite_r;
  assign paddr_o     = paddr_r;
  assign pwdata_o    = pwdata_r;
  assign pstrb_o     = pstrb_r;

endmodule

// File: tb/tb_apb_alarm_host.sv
// Scoreboard bench for apb_alarm_host: driver pushes expected responses and APB
// transfers, an APB slave model and a response monitor pop and compare.
`timescale 1ns/1ps
module tb_apb_alarm_host;

  localparam int          TMO  = 4;
  localparam logic [31:0] AMAX = 32'h8;

  logic        pclk_i = 1'b0;
  logic        preset_i;
  logic        cmd_valid_i, cmd_write_i;
  logic [31:0] cmd_addr_i, cmd_wdata_i;
  logic [3:0]  cmd_strb_i;
  logic        cmd_ready_o, rsp_valid_o, rsp_err_o;
  logic [31:0] rsp_rdata_o, paddr_o, pwdata_o;
  logic        psel_o, penable_o, pwrite_o;
  logic [3:0]  pstrb_o;
  logic        pready_i, pslverr_i;
  logic [31:0] prdata_i;

  apb_alarm_host #(.TIMEOUT(TMO), .ADDR_MAX(AMAX)) dut (
    .pclk_i(pclk_i), .preset_i(preset_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
    .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i), .cmd_strb_i(cmd_strb_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .paddr_o(paddr_o), .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
    .pwdata_o(pwdata_o), .pstrb_o(pstrb_o),
    .pready_i(pready_i), .prdata_i(prdata_i), .pslverr_i(pslverr_i)
  );

  always #5 pclk_i = ~pclk_i;

  int cyc = 0;
  always @(posedge pclk_i) cyc <= cyc + 1;

  typedef struct { logic err; logic [31:0] rdata; int cyc; } rsp_t;
  typedef struct {
    logic wr; logic [31:0] addr; logic [31:0] wdata; logic [3:0] strb;
    int wt; logic [31:0] rd; logic slverr;
  } apb_t;

  rsp_t rsp_q[$];
  apb_t apb_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // APB slave model: checks each transfer against the queue and answers after the programmed wait states.
  apb_t cur;
  int   acc = 0;
  always @(negedge pclk_i) begin
    if (preset_i) begin
      pready_i = 1'b0; prdata_i = 32'h0; pslverr_i = 1'b0;
    end else if (psel_o && !penable_o) begin
      if (apb_q.size() == 0) begin
        fail_now("unexpected_psel");
      end else begin
        cur = apb_q.pop_front();
        chk("setup_paddr", paddr_o, cur.addr);
        chk("setup_pwrite", pwrite_o, cur.wr);
        chk("setup_pwdata", pwdata_o, cur.wdata);
        chk("setup_pstrb", pstrb_o, cur.wr ? cur.strb : 4'h0);
      end
      acc = 0;
      pready_i = 1'($urandom); prdata_i = $urandom; pslverr_i = 1'($urandom);
    end else if (psel_o && penable_o) begin
      chk("access_paddr", paddr_o, cur.addr);
      chk("access_pwrite", pwrite_o, cur.wr);
      chk("access_pwdata", pwdata_o, cur.wdata);
      chk("access_pstrb", pstrb_o, cur.wr ? cur.strb : 4'h0);
      if (acc == cur.wt) begin
        pready_i = 1'b1; prdata_i = cur.rd; pslverr_i = cur.slverr;
      end else begin
        pready_i = 1'b0; prdata_i = $urandom; pslverr_i = 1'($urandom);
      end
      acc++;
    end else begin
      if (penable_o) fail_now("penable_without_psel");
      pready_i = 1'($urandom); prdata_i = $urandom; pslverr_i = 1'($urandom);
    end
  end

  // Response monitor: pops the scoreboard on each pulse, checks hold values between pulses.
  logic        ready_next = 1'b0;
  logic [31:0] last_rd = 32'h0;
  logic        last_err = 1'b0;
  rsp_t        e;
  always @(negedge pclk_i) begin
    if (preset_i) begin
      last_rd = 32'h0; last_err = 1'b0; ready_next = 1'b0;
    end else begin
      if (ready_next) begin
        chk("ready_after_resp", cmd_ready_o, 1'b1);
        ready_next = 1'b0;
      end
      if (rsp_valid_o) begin
        if (rsp_q.size() == 0) begin
          fail_now("unexpected_rsp");
        end else begin
          e = rsp_q.pop_front();
          chk("rsp_rdata", rsp_rdata_o, e.rdata);
          chk("rsp_err", rsp_err_o, e.err);
          chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
          chk("bus_idle_in_resp", {30'd0, psel_o, penable_o}, 32'd0);
          chk("ready_low_in_resp", cmd_ready_o, 1'b0);
          last_rd = e.rdata; last_err = e.err; ready_next = 1'b1;
        end
      end else begin
        chk("rdata_hold", rsp_rdata_o, last_rd);
        chk("err_hold", rsp_err_o, last_err);
      end
    end
  end

  task automatic drive_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, output logic ok);
    int guard = 0;
    @(negedge pclk_i);
    cmd_valid_i = 1'b1; cmd_write_i = wr; cmd_addr_i = addr;
    cmd_wdata_i = wdata; cmd_strb_i = strb;
    while (!cmd_ready_o && guard < 200) begin
      @(negedge pclk_i);
      guard++;
    end
    ok = cmd_ready_o;
    if (!ok) begin
      fail_now("accept_timeout");
      cmd_valid_i = 1'b0;
    end
  endtask

  task automatic release_cmd();
    @(negedge pclk_i);
    cmd_valid_i = 1'b0; cmd_write_i = 1'($urandom); cmd_addr_i = $urandom;
    cmd_wdata_i = $urandom; cmd_strb_i = 4'($urandom);
  endtask

  // Reference model: response contents and arrival cycle from the transfer rules.
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input int wt, input logic [31:0] rd,
                       input logic sle);
    logic ok, bad;
    rsp_t r;
    apb_t a;
    drive_cmd(wr, addr, wdata, strb, ok);
    if (ok) begin
      bad = (addr % 4 != 0) || (addr > AMAX);
      if (bad) begin
        r.err = 1'b1; r.rdata = 32'h0; r.cyc = cyc + 1;
      end else if (wt >= TMO) begin
        r.err = 1'b1; r.rdata = 32'h0; r.cyc = cyc + 2 + TMO;
      end else begin
        r.err = sle; r.rdata = wr ? 32'h0 : rd; r.cyc = cyc + 3 + wt;
      end
      rsp_q.push_back(r);
      if (!bad) begin
        a.wr = wr; a.addr = addr; a.wdata = wdata; a.strb = strb;
        a.wt = wt; a.rd = rd; a.slverr = sle;
        apb_q.push_back(a);
      end
      release_cmd();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready_o, 1'b1);
    chk({tag, "_rsp_valid"}, rsp_valid_o, 1'b0);
    chk({tag, "_rsp_rdata"}, rsp_rdata_o, 32'h0);
    chk({tag, "_rsp_err"}, rsp_err_o, 1'b0);
    chk({tag, "_psel"}, psel_o, 1'b0);
    chk({tag, "_penable"}, penable_o, 1'b0);
    chk({tag, "_pwrite"}, pwrite_o, 1'b0);
    chk({tag, "_paddr"}, paddr_o, 32'h0);
    chk({tag, "_pwdata"}, pwdata_o, 32'h0);
    chk({tag, "_pstrb"}, pstrb_o, 4'h0);
  endtask

  task automatic reset_mid_read();
    logic ok;
    apb_t a;
    int guard = 0;
    drive_cmd(1'b0, 32'h8, 32'h1234_5678, 4'hF, ok);
    if (ok) begin
      a.wr = 1'b0; a.addr = 32'h8; a.wdata = 32'h1234_5678; a.strb = 4'hF;
      a.wt = 3; a.rd = 32'hDEAD_BEEF; a.slverr = 1'b0;
      apb_q.push_back(a);
      release_cmd();
      while (!(psel_o && penable_o) && guard < 20) begin
        @(negedge pclk_i);
        guard++;
      end
      chk("first_access_seen", penable_o, 1'b1);
      @(posedge pclk_i);
      #1;
      chk("second_access_before_reset", penable_o, 1'b1);
      preset_i = 1'b1;
      #1;
      check_reset_outputs("midreset");
      rsp_q.delete();
      apb_q.delete();
      repeat (3) @(negedge pclk_i);
      preset_i = 1'b0;
    end
  endtask

  initial begin
    int guard = 0;
    logic [31:0] addr;
    preset_i = 1'b1;
    cmd_valid_i = 1'b0; cmd_write_i = 1'b0; cmd_addr_i = 32'h0;
    cmd_wdata_i = 32'h0; cmd_strb_i = 4'h0;
    repeat (3) @(negedge pclk_i);
    check_reset_outputs("reset");
    preset_i = 1'b0;

    issue(1'b1, 32'h0, 32'h0001_1230, 4'hF, 0, 32'h0, 1'b0);
    issue(1'b0, 32'h8, 32'hA5A5_5A5A, 4'h3, 3, 32'h0000_0945, 1'b0);
    issue(1'b1, 32'h4, 32'h0000_00FF, 4'h1, 0, 32'h0, 1'b1);
    issue(1'b0, 32'h6, 32'h0, 4'hF, 0, 32'h0, 1'b0);
    issue(1'b1, 32'hC, 32'h7, 4'hF, 0, 32'h0, 1'b0);
    issue(1'b0, 32'h0, 32'h0, 4'h0, 1000, 32'h1111_2222, 1'b0);
    issue(1'b0, 32'h4, 32'h0, 4'h0, TMO - 1, 32'h3333_4444, 1'b0);
    reset_mid_read();
    issue(1'b0, 32'h8, 32'h0, 4'h0, 0, 32'h0000_0ABC, 1'b0);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0: addr = 32'h0;
        1: addr = 32'h4;
        2: addr = 32'h8;
        3: addr = 32'hC;
        4: addr = 32'($urandom_range(0, 15));
        default: addr = $urandom;
      endcase
      issue(1'($urandom), addr, $urandom, 4'($urandom), $urandom_range(0, 5),
            $urandom, 1'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge pclk_i);
    end

    while ((rsp_q.size() != 0 || apb_q.size() != 0) && guard < 100) begin
      @(negedge pclk_i);
      guard++;
    end
    if (rsp_q.size() != 0 || apb_q.size() != 0) fail_now("drain_timeout");
    repeat (2) @(negedge pclk_i);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_alarm_host.md
# apb_alarm_host

APB initiator that drives the alarm peripheral's APB port from a simple valid/ready command interface. A controller (button FSM, UART bridge, or test sequencer) issues single read/write commands, and this block turns each one into a compliant APB SETUP/ACCESS transfer. It waits for `pready_i`, enforces a wait-state timeout and returns read data and error status as a one-cycle response. It sits between the control logic and the alarm peripheral's `psel`/`penable`/`pwrite`/`paddr`/`pwdata`/`pstrb` inputs.

## Interface
Parameters:
- `TIMEOUT` (default 16): maximum ACCESS cycles without `pready_i` before the transfer is aborted; legal range 1..255.
- `ADDR_MAX` (default 32'h8): highest legal register address; commands above it are rejected locally.

Ports. Reset is asynchronous and active-high.
- `pclk_i`  in  1  clock; all logic is on the rising edge.
- `preset_i`  in  1  reset, asynchronous and active-high.
- `cmd_valid_i`  in  1  command request.
- `cmd_ready_o`  out  1  command accepted when high together with `cmd_valid_i`.
- `cmd_write_i`  in  1  1 = write, 0 = read.
- `cmd_addr_i`  in  32  byte address.
- `cmd_wdata_i`  in  32  write data.
- `cmd_strb_i`  in  4  write byte strobes; ignored on reads.
- `rsp_valid_o`  out  1  one-cycle response pulse.
- `rsp_rdata_o`  out  32  read data; 0 for writes and errors.
- `rsp_err_o`  out  1  error flag, qualified by `rsp_valid_o`.
- `paddr_o`  out  32  APB address.
- `psel_o`  out  1  APB select.
- `penable_o`  out  1  APB enable.
- `pwrite_o`  out  1  APB direction.
- `pwdata_o`  out  32  APB write data.
- `pstrb_o`  out  4  APB strobes; forced to 0 on reads.
- `pready_i`  in  1  APB ready from the slave.
- `prdata_i`  in  32  APB read data.
- `pslverr_i`  in  1  APB slave error.

## Operation
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - `cmd_ready_o` is 1.
  - On `cmd_valid_i`, the block latches write, addr, wdata and strb into holding registers.
  - If `cmd_addr_i[1:0]` != 0 or `cmd_addr_i` > `ADDR_MAX`, it goes to RESP with err=1. No APB activity occurs.
  - Otherwise it goes to SETUP.
- SETUP:
  - `psel_o`=1, `penable_o`=0.
  - `paddr_o`, `pwrite_o`, `pwdata_o` and `pstrb_o` are driven from the holding registers.
  - Always goes to ACCESS.
- ACCESS:
  - `psel_o`=1, `penable_o`=1.
  - All APB outputs are held stable.
  - The wait counter increments each cycle.
  - If `pready_i`=1: latch rdata = (read ? `prdata_i` : 0) and err = `pslverr_i`, then go to RESP.
  - Else if the counter reaches `TIMEOUT`: err=1, rdata=0, go to RESP (abort).
- RESP:
  - `psel_o`=0, `penable_o`=0.
  - `rsp_valid_o`=1 for exactly this cycle, with the latched rdata and err.
  - Goes to IDLE.
- `cmd_ready_o` is 0 in SETUP, ACCESS and RESP. Commands presented in those states are neither consumed nor lost; the requester holds them.
- `rsp_rdata_o` and `rsp_err_o` keep their last values outside RESP.
- The wait counter is 8 bits wide, clears on entry to SETUP, and saturates rather than wrapping.
- `pready_i` arriving in the same cycle as the timeout compare counts as success; `pready_i` has priority.
- `pslverr_i` is sampled only when `pready_i`=1 in ACCESS. Outside ACCESS, `pready_i`, `pslverr_i` and `prdata_i` are ignored.

## Timing
- Reset values while `preset_i` is high, applied immediately and asynchronously:
  - state = IDLE.
  - `cmd_ready_o`=1.
  - `rsp_valid_o`=0, `rsp_rdata_o`=0, `rsp_err_o`=0.
  - `psel_o`=0, `penable_o`=0, `pwrite_o`=0, `paddr_o`=0, `pwdata_o`=0, `pstrb_o`=0.
  - Wait counter = 0.
- Reset asserted mid-transfer abandons the transfer: no response is issued and the APB bus goes idle at once.
- Let cycle 0 be command acceptance:
  - SETUP is cycle 1.
  - First ACCESS is cycle 2.
  - With `pready_i` high in cycle 2+N, RESP is cycle 3+N.
  - The next command can be accepted in cycle 4+N.
- With zero wait states, this gives 4 cycles per transfer. The alarm slave registers `pready` from `psel`, so it is ready in the first ACCESS cycle (N=0).
- A local reject makes RESP cycle 1; the next accept is in cycle 2.
- Timeout: with `pready_i` held low, the last ACCESS cycle is cycle 1+`TIMEOUT` and RESP is cycle 2+`TIMEOUT`.

## Test plan
- Write to address 0x0 with data 0x0001_1230 and strb 0xF; slave ready in the first ACCESS cycle.
  - Required: SETUP in cycle 1, ACCESS in cycle 2, `rsp_valid_o` in cycle 3 with err=0 and rdata=0.
  - APB outputs stable across cycles 1–2; `cmd_ready_o` high again in cycle 4.
- Read address 0x8 with the slave returning `prdata_i`=0x0000_0945 after 3 wait states.
  - Required: `rsp_rdata_o`=0x0000_0945, err=0, `rsp_valid_o` in cycle 6, `pstrb_o`=0.
- Write to address 0x4 with the slave raising `pslverr_i` together with `pready_i`.
  - Required: `rsp_err_o`=1 on the response pulse; the bus returns to idle in the RESP cycle.
- Misaligned address 0x6, and out-of-range address 0xC.
  - Required: `psel_o` never rises; RESP in cycle 1 with err=1 and rdata=0.
- `TIMEOUT`=4 with `pready_i` tied low.
  - Required: exactly 4 ACCESS cycles, then RESP with err=1 and rdata=0.
  - Repeat with `pready_i` rising in the 4th ACCESS cycle: required err=0.
- Assert `preset_i` in the second ACCESS cycle of a read.
  - Required: all outputs at their reset values in the same cycle and no `rsp_valid_o` pulse.
  - After deassertion, a new command completes normally.
